// File: rtl/fast_pkg.sv
// Shared definitions for the FAST corner-score path: reader FSM states,
// default score width and the SRAM4 address-width helper.
// No ports; imported by the reader, its raster counter and its stream interface.
package fast_pkg;

    localparam int SCORE_W_DEFAULT = 12;

    typedef enum logic [2:0] {
        KP_IDLE,
        KP_READ,
        KP_WAIT,
        KP_EMIT,
        KP_DONE
    } kp_state_t;

    // SRAM4 address width: one bit wider than needed to count the capacity.
    function automatic int addr_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/corner_keypoint_reader_if.sv
// Keypoint stream (valid/ready) from the corner reader to the descriptor stage.
// Ports: kp_valid/kp_x/kp_y/kp_score driven by master, kp_ready driven by slave.
// Payload must stay stable while kp_valid is high and kp_ready is low.
interface corner_keypoint_reader_if
    import fast_pkg::*;
#(
    parameter int ADDR_W  = addr_w(10),
    parameter int SCORE_W = SCORE_W_DEFAULT
);
    logic               kp_valid;
    logic               kp_ready;
    logic [ADDR_W-1:0]  kp_x;
    logic [ADDR_W-1:0]  kp_y;
    logic [SCORE_W-1:0] kp_score;

    modport master (output kp_valid, kp_x, kp_y, kp_score, input kp_ready);
    modport slave  (input kp_valid, kp_x, kp_y, kp_score, output kp_ready);
endinterface

// File: rtl/raster_counter.sv
// Raster position counter: x runs first, wraps at max_x-1 and bumps y.
// Ports: clk/rst, clear (to 0,0), advance (step once), max_x/max_y bounds;
// outputs registered x/y and combinational last (at max_x-1, max_y-1).
module raster_counter
    import fast_pkg::*;
#(
    parameter int AW = addr_w(10)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  logic [AW-1:0] max_x,
    input  logic [AW-1:0] max_y,
    output logic [AW-1:0] x,
    output logic [AW-1:0] y,
    output logic          last
);

    logic x_end;
    logic y_end;

    assign x_end = (x == max_x - 1'b1);
    assign y_end = (y == max_y - 1'b1);
    assign last  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_end) begin
                x <= '0;
                // Stepping past the last pixel wraps to (0,0); harmless, the FSM stops there.
                y <= y_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/corner_keypoint_reader.sv
// Raster-scans SRAM4 corner scores and emits (x, y, score) for scores >= MIN_SCORE.
// Ports: start/max_x/max_y control, SRAM4 read port (read_SRAM4, x/y_addr4, score_in),
// keypoint stream interface kp, status busy/done/kp_count. All outputs registered.
module corner_keypoint_reader
    import fast_pkg::*;
#(
    parameter int X_MAX     = 10,
    parameter int Y_MAX     = 10,
    parameter int SCORE_W   = SCORE_W_DEFAULT,
    parameter int MIN_SCORE = 1,
    localparam int DW = $clog2(X_MAX),
    localparam int AW = addr_w(X_MAX),
    localparam int CW = $clog2(X_MAX * Y_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DW-1:0]        max_x,
    input  logic [DW-1:0]        max_y,
    output logic                 read_SRAM4,
    output logic [AW-1:0]        x_addr4,
    output logic [AW-1:0]        y_addr4,
    input  logic [SCORE_W-1:0]   score_in,
    corner_keypoint_reader_if.master kp,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        kp_count
);

    kp_state_t     state;
    kp_state_t     state_n;
    logic [AW-1:0] dim_x;
    logic [AW-1:0] dim_y;
    logic [AW-1:0] clamp_x;
    logic [AW-1:0] clamp_y;
    logic [AW-1:0] pos_x;
    logic [AW-1:0] pos_y;
    logic          last;
    logic          clear;
    logic          advance;
    logic          take;
    logic          accept;

    assign clamp_x = (AW'(max_x) > AW'(X_MAX)) ? AW'(X_MAX) : AW'(max_x);
    assign clamp_y = (AW'(max_y) > AW'(Y_MAX)) ? AW'(Y_MAX) : AW'(max_y);

    raster_counter #(.AW(AW)) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (advance),
        .max_x   (dim_x),
        .max_y   (dim_y),
        .x       (pos_x),
        .y       (pos_y),
        .last    (last)
    );

    // The counter registers double as the SRAM4 address registers.
    assign x_addr4 = pos_x;
    assign y_addr4 = pos_y;

    always_ff @(posedge clk) begin
        if (rst) state <= KP_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        clear   = 1'b0;
        advance = 1'b0;
        take    = 1'b0;
        accept  = 1'b0;
        case (state)
            KP_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_n = (clamp_x == '0 || clamp_y == '0) ? KP_DONE : KP_READ;
                end
            end
            KP_READ: state_n = KP_WAIT;
            KP_WAIT: begin
                if (score_in >= SCORE_W'(MIN_SCORE)) begin
                    take    = 1'b1;
                    state_n = KP_EMIT;
                end else begin
                    advance = 1'b1;
                    state_n = last ? KP_DONE : KP_READ;
                end
            end
            KP_EMIT: begin
                if (kp.kp_ready) begin
                    accept  = 1'b1;
                    advance = 1'b1;
                    state_n = last ? KP_DONE : KP_READ;
                end
            end
            KP_DONE: state_n = KP_IDLE;
            default: state_n = KP_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_SRAM4  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            kp.kp_valid <= 1'b0;
            kp.kp_x     <= '0;
            kp.kp_y     <= '0;
            kp.kp_score <= '0;
            kp_count    <= '0;
            dim_x       <= '0;
            dim_y       <= '0;
        end else begin
            read_SRAM4  <= (state_n == KP_READ);
            busy        <= (state_n != KP_IDLE);
            done        <= (state_n == KP_DONE);
            kp.kp_valid <= (state_n == KP_EMIT);
            if (clear) begin
                dim_x    <= clamp_x;
                dim_y    <= clamp_y;
                kp_count <= '0;
            end else if (accept) begin
                kp_count <= kp_count + 1'b1;
            end
            if (take) begin
                kp.kp_x     <= pos_x;
                kp.kp_y     <= pos_y;
                kp.kp_score <= score_in;
            end
        end
    end

endmodule

// File: tb/tb_corner_keypoint_reader.sv
// Bench for corner_keypoint_reader: SRAM4 image model, keypoint reference list
// built by plain raster loops, directed and random scans on two instances.
module tb_corner_keypoint_reader;

    typedef struct packed {
        logic [4:0]  x;
        logic [4:0]  y;
        logic [11:0] s;
    } kp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic [3:0]  max_x;
    logic [3:0]  max_y;
    logic        rdy;
    logic        sel_b;

    logic        rd_a, rd_b, busy_a, busy_b, done_a, done_b;
    logic [4:0]  xa, ya, xb, yb;
    logic [6:0]  cnt_a, cnt_b;
    logic [11:0] score_a = '0;
    logic [11:0] score_b = '0;

    logic [11:0] mem [0:9][0:9];
    kp_t         exp_q [$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    corner_keypoint_reader_if #(.ADDR_W(5), .SCORE_W(12)) ifa ();
    corner_keypoint_reader_if #(.ADDR_W(5), .SCORE_W(12)) ifb ();
    assign ifa.kp_ready = rdy;
    assign ifb.kp_ready = rdy;

    corner_keypoint_reader #(.X_MAX(10), .Y_MAX(10), .SCORE_W(12), .MIN_SCORE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .max_x(max_x), .max_y(max_y),
        .read_SRAM4(rd_a), .x_addr4(xa), .y_addr4(ya), .score_in(score_a),
        .kp(ifa), .busy(busy_a), .done(done_a), .kp_count(cnt_a)
    );

    corner_keypoint_reader #(.X_MAX(10), .Y_MAX(10), .SCORE_W(12), .MIN_SCORE(20)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .max_x(max_x), .max_y(max_y),
        .read_SRAM4(rd_b), .x_addr4(xb), .y_addr4(yb), .score_in(score_b),
        .kp(ifb), .busy(busy_b), .done(done_b), .kp_count(cnt_b)
    );

    // SRAM4 model: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_a) score_a <= mem[ya][xa];
        if (rd_b) score_b <= mem[yb][xb];
    end

    logic        o_read, o_valid, o_busy, o_done;
    logic [4:0]  o_xa, o_ya, o_kx, o_ky;
    logic [11:0] o_ks;
    logic [6:0]  o_cnt;
    assign o_read  = sel_b ? rd_b : rd_a;
    assign o_valid = sel_b ? ifb.kp_valid : ifa.kp_valid;
    assign o_busy  = sel_b ? busy_b : busy_a;
    assign o_done  = sel_b ? done_b : done_a;
    assign o_xa    = sel_b ? xb : xa;
    assign o_ya    = sel_b ? yb : ya;
    assign o_kx    = sel_b ? ifb.kp_x : ifa.kp_x;
    assign o_ky    = sel_b ? ifb.kp_y : ifa.kp_y;
    assign o_ks    = sel_b ? ifb.kp_score : ifa.kp_score;
    assign o_cnt   = sel_b ? cnt_b : cnt_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_mem();
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                mem[y][x] = '0;
    endtask

    // Reference: every pixel of the active window in raster order whose score passes.
    task automatic build_model(input int mx, input int my, input int minsc);
        exp_q.delete();
        for (int y = 0; y < my; y++)
            for (int x = 0; x < mx; x++)
                if (int'(mem[y][x]) >= minsc)
                    exp_q.push_back('{x: 5'(x), y: 5'(y), s: mem[y][x]});
    endtask

    // One full scan. Timing reference: READ/DONE is the first cycle after start is
    // sampled (c=1); each pixel costs 2 cycles, each keypoint 1 more plus its stall.
    task automatic run_scan(input bit sel, input int mxr, input int myr, input int stall_fix,
                            input bit rnd, input int restart_at, input int minsc,
                            output int done_c);
        int mx, my, n, nkp, vcnt, stall_k, rd_k, exp_dc;
        bit seen;
        mx = (mxr > 10) ? 10 : mxr;
        my = (myr > 10) ? 10 : myr;
        build_model(mx, my, minsc);
        n       = exp_q.size();
        stall_k = rnd ? int'($urandom_range(0, 3)) : stall_fix;
        exp_dc  = 1 + 2 * mx * my;
        nkp = 0; vcnt = 0; rd_k = 0; seen = 1'b0; done_c = -1;
        sel_b = sel;
        max_x = 4'(mxr);
        max_y = 4'(myr);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 3000 && !seen; c++) begin
            if (c == restart_at) begin
                max_x = 4'd2;
                max_y = 4'd2;
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (o_read) begin
                if (rd_k < mx * my) begin
                    chk("rd_x", 32'(o_xa), 32'(rd_k % mx));
                    chk("rd_y", 32'(o_ya), 32'(rd_k / mx));
                end
                rd_k++;
            end
            if (o_valid) begin
                if (nkp < n) begin
                    chk("kp_x", 32'(o_kx), 32'(exp_q[nkp].x));
                    chk("kp_y", 32'(o_ky), 32'(exp_q[nkp].y));
                    chk("kp_score", 32'(o_ks), 32'(exp_q[nkp].s));
                end
                if (vcnt >= stall_k) begin
                    rdy = 1'b1;
                    nkp++;
                    exp_dc += 1 + stall_k;
                    vcnt = 0;
                    stall_k = rnd ? int'($urandom_range(0, 3)) : stall_fix;
                end else begin
                    rdy = 1'b0;
                    vcnt++;
                end
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            if (o_done) begin
                seen   = 1'b1;
                done_c = c;
                chk("done_cycle", 32'(c), 32'(exp_dc));
                chk("kp_count", 32'(o_cnt), 32'(n));
                chk("accepted", 32'(nkp), 32'(n));
                chk("reads", 32'(rd_k), 32'(mx * my));
            end else begin
                chk("busy", 32'(o_busy), 32'd1);
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_single", 32'(o_done), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int dc0, dc5, dc;
        bit seen;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; max_x = '0; max_y = '0;
        rdy = 1'b0; sel_b = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_read", 32'(rd_a), 32'd0);
        chk("rst_valid", 32'(ifa.kp_valid), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_addr", 32'({xa, ya}), 32'd0);
        chk("rst_payload", 32'({ifa.kp_x, ifa.kp_y, ifa.kp_score}), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_b", 32'({rd_b, busy_b, done_b, ifb.kp_valid, cnt_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Flat 4x4 image.
        run_scan(1'b0, 4, 4, 0, 1'b0, 0, 1, dc);
        chk("flat_duration", 32'(dc), 32'd33);

        // Mixed scores, no backpressure, then 5-cycle stall per keypoint.
        clear_mem();
        mem[3][3] = 12'd25;
        mem[2][6] = 12'd40;
        mem[9][9] = 12'd1;
        run_scan(1'b0, 10, 10, 0, 1'b0, 0, 1, dc0);
        run_scan(1'b0, 10, 10, 5, 1'b0, 0, 1, dc5);
        chk("bp_extra", 32'(dc5 - dc0), 32'd15);

        // Zero dimension.
        run_scan(1'b0, 0, 5, 0, 1'b0, 0, 1, dc);

        // Start re-pulsed mid-scan is ignored.
        run_scan(1'b0, 10, 10, 1, 1'b0, 7, 1, dc);

        // Reset while a keypoint is pending.
        sel_b = 1'b0; max_x = 4'd10; max_y = 4'd10; rdy = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (ifa.kp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rst_reach_emit", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_outputs", 32'({rd_a, ifa.kp_valid, busy_a, done_a}), 32'd0);
        chk("mid_rst_addr", 32'({xa, ya}), 32'd0);
        chk("mid_rst_payload", 32'({ifa.kp_x, ifa.kp_y, ifa.kp_score}), 32'd0);
        chk("mid_rst_count", 32'(cnt_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", 32'({done_a, busy_a}), 32'd0);
        end

        // Fresh scan after reset starts from (0,0).
        run_scan(1'b0, 10, 10, 0, 1'b0, 0, 1, dc);

        // Threshold boundary on the MIN_SCORE=20 instance.
        clear_mem();
        mem[0][1] = 12'd19;
        mem[1][0] = 12'd20;
        mem[2][2] = 12'd4095;
        run_scan(1'b1, 3, 3, 0, 1'b0, 0, 20, dc);
        chk("thr_count", 32'(cnt_b), 32'd2);

        // Random images, dimensions (including clamped ones) and stalls.
        for (int r = 0; r < 6; r++) begin
            for (int y = 0; y < 10; y++)
                for (int x = 0; x < 10; x++)
                    mem[y][x] = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'd0;
            run_scan(1'b0, int'($urandom_range(1, 15)), int'($urandom_range(1, 15)),
                     0, 1'b1, 0, 1, dc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
